// File: rtl/cntr_timer.sv
// cntr_timer: wishbone timer with prescaled 32-bit counter, compare match, overflow and input capture
module cntr_timer #(
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        capture_i,
    output logic        irq_o
);
    logic [31:0] count, compare, capture, count_inc, rdata;
    logic [PRESCALE_W-1:0] prescale, tick;
    logic en, irq_en, match, ovf, cap, cap_prev;
    logic access, wr, wr_cnt, wr_cmp, wr_ctrl, wr_stat, wr_pre, inc, bump, cap_edge;

    assign access    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr        = access & wb_we_i;
    assign wr_cnt    = wr & (wb_adr_i == 4'd0);
    assign wr_cmp    = wr & (wb_adr_i == 4'd1);
    assign wr_ctrl   = wr & (wb_adr_i == 4'd2);
    assign wr_stat   = wr & (wb_adr_i == 4'd3);
    assign wr_pre    = wr & (wb_adr_i == 4'd4);
    assign inc       = en & (tick == prescale);
    // a COUNT write on the same edge suppresses the increment and its flags
    assign bump      = inc & ~wr_cnt;
    assign count_inc = count + 32'd1;
    assign cap_edge  = capture_i & ~cap_prev;
    assign irq_o     = match & irq_en;

    always_comb begin
        rdata = wb_adr_i == 4'd0 ? count :
                wb_adr_i == 4'd1 ? compare :
                wb_adr_i == 4'd2 ? {30'd0, irq_en, en} :
                wb_adr_i == 4'd3 ? {29'd0, cap, ovf, match} :
                wb_adr_i == 4'd4 ? {{(32-PRESCALE_W){1'b0}}, prescale} :
                wb_adr_i == 4'd5 ? capture : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            count    <= '0;
            compare  <= '0;
            capture  <= '0;
            prescale <= '0;
            tick     <= '0;
            en       <= 1'b0;
            irq_en   <= 1'b0;
            match    <= 1'b0;
            ovf      <= 1'b0;
            cap      <= 1'b0;
            cap_prev <= 1'b0;
        end else begin
            wb_ack_o <= access;
            wb_dat_o <= (access & ~wb_we_i) ? rdata : 32'd0;
            cap_prev <= capture_i;
            tick     <= wr_cnt ? '0 : !en ? tick : inc ? '0 : tick + 1'b1;
            count    <= wr_cnt ? wb_dat_i : inc ? count_inc : count;
            if (wr_cmp) compare <= wb_dat_i;
            if (wr_ctrl) {irq_en, en} <= wb_dat_i[1:0];
            if (wr_pre) prescale <= wb_dat_i[PRESCALE_W-1:0];
            if (cap_edge) capture <= count;
            // flag sets take priority over same-edge write-one-to-clear
            match <= (match & ~(wr_stat & wb_dat_i[0])) | (bump & (count_inc == compare));
            ovf   <= (ovf & ~(wr_stat & wb_dat_i[1])) | (bump & (&count));
            cap   <= (cap & ~(wr_stat & wb_dat_i[2])) | cap_edge;
        end
    end
endmodule

// File: tb/tb_cntr_timer.sv
// tb_cntr_timer: directed self-checking bench for cntr_timer
module tb_cntr_timer;
    logic        clk = 1'b0;
    logic        rst, stb, cyc, we, cap_in;
    logic [3:0]  adr;
    logic [31:0] dat_i, dat_o, q;
    logic        ack, irq;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n;

    cntr_timer #(.PRESCALE_W(8)) dut (
        .clk(clk), .rst(rst), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .capture_i(cap_in), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic acc(input logic w, input logic [3:0] a, input logic [31:0] d, output logic [31:0] r);
        int k;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!ack && k < 4);
        chk("ack_latency", k, 1);
        r = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] r;
        acc(1'b1, a, d, r);
        chk("wr_dat_zero", r, 0);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] r;
        acc(1'b0, a, 32'd0, r);
        chk(tag, r, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; dat_i = '0; cap_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ack", ack, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_irq", irq, 0);
        for (int a = 0; a < 6; a++) begin
            acc(1'b0, 4'(a), 32'd0, q);
            chk("rd_after_rst", q, 0);
            @(posedge clk); #1;
            chk("ack_one_cycle", ack, 0);
        end
        wr_reg(4'd9, 32'hFFFF_FFFF);
        rd_chk("rd_unmapped", 4'd9, 0);
        wr_reg(4'd2, 32'hFFFF_FFFC);
        rd_chk("ctrl_upper_zero", 4'd2, 0);
        wr_reg(4'd4, 32'hFFFF_FFFF);
        rd_chk("prescale_mask", 4'd4, 32'h0000_00FF);
        wr_reg(4'd1, 32'h1234_5678);
        rd_chk("compare_rw", 4'd1, 32'h1234_5678);
        wr_reg(4'd1, 32'd0);

        // prescale by 4: 41 enabled edges before the read samples
        wr_reg(4'd4, 32'd3);
        wr_reg(4'd0, 32'd0);
        wr_reg(4'd2, 32'd1);
        repeat (40) @(posedge clk);
        rd_chk("count_prescaled", 4'd0, 32'd10);
        wr_reg(4'd2, 32'd0);
        repeat (10) @(posedge clk);
        rd_chk("count_frozen", 4'd0, 32'd11);

        // wrap: FFFFFFFE + 6 increments = 4, passing through 0 (also matches COMPARE=0)
        wr_reg(4'd4, 32'd0);
        wr_reg(4'd0, 32'hFFFF_FFFE);
        wr_reg(4'd2, 32'd1);
        repeat (4) @(posedge clk);
        wr_reg(4'd2, 32'd0);
        rd_chk("count_wrapped", 4'd0, 32'd4);
        rd_chk("status_ovf", 4'd3, 32'd3);
        wr_reg(4'd3, 32'd2);
        rd_chk("ovf_cleared", 4'd3, 32'd1);
        wr_reg(4'd3, 32'd1);
        rd_chk("status_clear", 4'd3, 32'd0);

        // compare match drives irq
        wr_reg(4'd1, 32'd5);
        wr_reg(4'd0, 32'd0);
        wr_reg(4'd2, 32'd3);
        chk("irq_low_start", irq, 0);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            chk("irq_at_count", irq, (i == 5) ? 32'd1 : 32'd0);
        end
        wr_reg(4'd2, 32'd2);
        chk("irq_held", irq, 1);
        wr_reg(4'd3, 32'd1);
        chk("irq_cleared", irq, 0);
        wr_reg(4'd0, 32'd5);
        rd_chk("load_no_match", 4'd3, 32'd0);
        chk("irq_after_load", irq, 0);

        // capture edge, then held high
        wr_reg(4'd0, 32'h100);
        @(posedge clk); #1 cap_in = 1'b1;
        repeat (3) @(posedge clk);
        wr_reg(4'd0, 32'h200);
        repeat (3) @(posedge clk);
        rd_chk("capture_val", 4'd5, 32'h100);
        rd_chk("status_cap", 4'd3, 32'd4);
        wr_reg(4'd5, 32'hDEAD_BEEF);
        rd_chk("capture_ro", 4'd5, 32'h100);
        cap_in = 1'b0;
        wr_reg(4'd3, 32'd4);
        rd_chk("cap_cleared", 4'd3, 32'd0);

        // held strobe: acks every other cycle; third write lands on the matching edge
        wr_reg(4'd1, 32'h50);
        wr_reg(4'd0, 32'h4A);
        wr_reg(4'd2, 32'd1);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 4'd3; dat_i = 32'd1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                n++;
                chk("burst_wr_dat", dat_o, 0);
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        chk("burst_acks", n, 3);
        wr_reg(4'd2, 32'd0);
        rd_chk("set_beats_w1c", 4'd3, 32'd1);

        // reset during an access drops the write and the ack
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 4'd1; dat_i = 32'h77; rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ack", ack, 0);
        rst = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        rd_chk("rst_mid_compare", 4'd1, 32'd0);
        rd_chk("rst_mid_count", 4'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
